// File: rtl/lane_deskew.sv
// Two-lane receive deskew: per-lane FIFOs realigned on a shared ALIGN_WORD marker pair.
// Latency: a word written at edge k reaches the registered outputs after edge k+1 at the earliest.
// Backpressure: none upstream; FIFO overflow or marker misalignment flushes both lanes and re-searches.
module lane_deskew #(
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 4,
    parameter logic [DATA_W-1:0]  ALIGN_WORD = 32'hBCBCBCBC
) (
    input  logic              clk_f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] lane_0_in,
    input  logic              valid_0_in,
    input  logic [DATA_W-1:0] lane_1_in,
    input  logic              valid_1_in,
    output logic [DATA_W-1:0] lane_0_out,
    output logic [DATA_W-1:0] lane_1_out,
    output logic              valid_out,
    output logic              aligned,
    output logic              skew_err,
    output logic [2:0]        skew,
    output logic              lead_lane
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t            state, state_n;

    logic [DATA_W-1:0] mem    [2][DEPTH];
    logic [AW-1:0]     rd_ptr [2];
    logic [AW-1:0]     wr_ptr [2];
    logic [CW-1:0]     count  [2];
    logic [DATA_W-1:0] din    [2];
    logic [DATA_W-1:0] head   [2];
    logic [1:0]        din_vld;
    logic [1:0]        not_empty;
    logic [1:0]        is_mark;
    logic [1:0]        hold;
    logic [1:0]        pop;
    logic [1:0]        ovf;
    logic              flush;
    logic              pair_vld;
    logic              acquire;
    logic              err;
    logic [2:0]        wait_cnt, wait_cnt_n;
    logic              hold_lane, hold_lane_n;

    assign din[0]     = lane_0_in;
    assign din[1]     = lane_1_in;
    assign din_vld    = {valid_1_in, valid_0_in};
    assign aligned    = (state == ALIGNED);

    // FIFO head words and their occupancy / marker status
    always_comb begin
        not_empty = '0;
        is_mark   = '0;
        for (int i = 0; i < 2; i++) begin
            head[i]      = mem[i][rd_ptr[i]];
            not_empty[i] = (count[i] != '0);
            is_mark[i]   = (head[i] == ALIGN_WORD);
        end
    end

    // Pop decisions, marker search / misalignment detection, overflow override
    always_comb begin
        pop         = '0;
        ovf         = '0;
        flush       = 1'b0;
        pair_vld    = 1'b0;
        acquire     = 1'b0;
        err         = 1'b0;
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        hold_lane_n = hold_lane;
        hold        = not_empty & is_mark;

        case (state)
            SEARCH: begin
                // Anything ahead of a marker is garbage; a marker is parked until its partner shows up.
                pop = not_empty & ~is_mark;
                if (hold == 2'b11) begin
                    pop        = 2'b11;
                    pair_vld   = 1'b1;
                    acquire    = 1'b1;
                    state_n    = ALIGNED;
                    wait_cnt_n = '0;
                end else if (hold != 2'b00) begin
                    wait_cnt_n  = (wait_cnt == 3'd7) ? 3'd7 : wait_cnt + 3'd1;
                    hold_lane_n = hold[1];
                end
            end
            ALIGNED: begin
                if (&not_empty) begin
                    pop = 2'b11;
                    // A marker on only one lane means the lanes have slipped relative to each other.
                    if (is_mark[0] ^ is_mark[1]) begin
                        err        = 1'b1;
                        flush      = 1'b1;
                        state_n    = SEARCH;
                        wait_cnt_n = '0;
                    end else begin
                        pair_vld = 1'b1;
                    end
                end
            end
        endcase

        for (int i = 0; i < 2; i++) begin
            ovf[i] = (count[i] == CW'(DEPTH)) && din_vld[i] && !pop[i];
        end

        // Overflow wins over any marker decision taken above on the same edge.
        if (|ovf) begin
            err        = 1'b1;
            flush      = 1'b1;
            pair_vld   = 1'b0;
            acquire    = 1'b0;
            state_n    = SEARCH;
            wait_cnt_n = '0;
        end
    end

    // FIFO pointers and occupancy; a flush also drops the words arriving on that edge
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (din_vld[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                count[i] <= count[i] + CW'(din_vld[i]) - CW'(pop[i]);
            end
        end
    end

    // FIFO storage; contents are meaningless until covered by count, so no reset
    always_ff @(posedge clk_f) begin
        for (int i = 0; i < 2; i++) begin
            if (din_vld[i] && !flush) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    // State, skew measurement and registered outputs
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= SEARCH;
            wait_cnt   <= '0;
            hold_lane  <= 1'b0;
            valid_out  <= 1'b0;
            skew_err   <= 1'b0;
            lane_0_out <= '0;
            lane_1_out <= '0;
            skew       <= '0;
            lead_lane  <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            hold_lane <= hold_lane_n;
            valid_out <= pair_vld;
            skew_err  <= err;
            if (pair_vld) begin
                lane_0_out <= head[0];
                lane_1_out <= head[1];
            end
            if (acquire) begin
                skew      <= wait_cnt;
                lead_lane <= (wait_cnt == 3'd0) ? 1'b0 : hold_lane;
            end
        end
    end

endmodule
